// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller.
// MC_JAL_EN adds the JAL state and the J-type immediate select.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBeq,
`ifdef MC_JAL_EN
      StJal,
`endif
      StTrap
   } state_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      logic [1:0] sel;
      sel = IMM_I;
      case (op)
         OP_SW:   sel = IMM_S;
         OP_BEQ:  sel = IMM_B;
`ifdef MC_JAL_EN
         OP_JAL:  sel = IMM_J;
`endif
         default: sel = IMM_I;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control-path bundle between the multicycle controller (master) and the
// datapath/memory side (slave).
interface multicycle_controller_if #(
   parameter int unsigned CNT_W = 32
);
   logic [6:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             trap_clr;
   logic             mem_req;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic             RegWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic [1:0]       ImmSrc;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, zero, mem_ready, trap_clr,
      output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      output trap, trap_cause, retired
   );

   modport slave (
      output op, zero, mem_ready, trap_clr,
      input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
      input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
      input  trap, trap_cause, retired
   );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Moore output decode of the controller state; only IRWrite/PCWrite look at
// mem_ready and zero. MC_JAL_EN adds the JAL output row.
module mc_output_decode
   import riscv_ctrl_pkg::*;
(
   input  state_e     i_state,
   input  logic [6:0] i_op,
   input  logic       i_mem_ready,
   input  logic       i_zero,
   output logic       o_mem_req,
   output logic       o_pc_write,
   output logic       o_adr_src,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_reg_write,
   output logic [1:0] o_result_src,
   output logic [1:0] o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic [1:0] o_imm_src,
   output logic       o_trap
);

   logic w_pc_update;
   logic w_branch;

   always_comb begin
      o_mem_req    = 1'b0;
      o_adr_src    = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_result_src = RES_ALUOUT;
      o_alu_src_a  = SRCA_PC;
      o_alu_src_b  = SRCB_RS2;
      o_alu_op     = ALUOP_ADD;
      o_trap       = 1'b0;
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;

      unique case (i_state)
         StFetch: begin
            o_mem_req    = 1'b1;
            o_alu_src_b  = SRCB_FOUR;
            o_result_src = RES_ALURESULT;
            o_ir_write   = i_mem_ready;
            w_pc_update  = i_mem_ready;
         end
         StDecode: begin
            // Precompute the branch/jump target into ALUOut.
            o_alu_src_a = SRCA_OLDPC;
            o_alu_src_b = SRCB_IMM;
         end
         StMemAdr: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
         end
         StMemRead: begin
            o_mem_req = 1'b1;
            o_adr_src = 1'b1;
         end
         StMemWb: begin
            o_result_src = RES_DATA;
            o_reg_write  = 1'b1;
         end
         StMemWrite: begin
            o_mem_req   = 1'b1;
            o_adr_src   = 1'b1;
            o_mem_write = 1'b1;
         end
         StExecR: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_op    = ALUOP_FUNCT;
         end
         StExecI: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_src_b = SRCB_IMM;
            o_alu_op    = ALUOP_FUNCT;
         end
         StAluWb: begin
            o_reg_write = 1'b1;
         end
         StBeq: begin
            o_alu_src_a = SRCA_RS1;
            o_alu_op    = ALUOP_SUB;
            w_branch    = 1'b1;
         end
`ifdef MC_JAL_EN
         StJal: begin
            // PC takes the target from ALUOut while the ALU forms OldPC + 4.
            o_alu_src_a = SRCA_OLDPC;
            o_alu_src_b = SRCB_FOUR;
            w_pc_update = 1'b1;
         end
`endif
         StTrap: begin
            o_trap = 1'b1;
         end
         default: begin
            o_trap = 1'b0;
         end
      endcase
   end

   assign o_pc_write = w_pc_update | (w_branch & i_zero);
   assign o_imm_src  = imm_src(i_op);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory stall timeout, trap handling and
// a retired-instruction counter. MC_JAL_EN enables execution of jal.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned WAIT_W      = 5,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);

   localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MEM_TIMEOUT - 1);

   state_e             r_state_q;
   state_e             w_state_d;
   logic [WAIT_W-1:0]  r_wait_q;
   logic [WAIT_W-1:0]  w_wait_d;
   logic [1:0]         r_cause_q;
   logic [1:0]         w_cause_d;
   logic [CNT_W-1:0]   r_retired_q;
   logic               w_mem_req;
   logic               w_stall;
   logic               w_limit;
   logic               w_retire;

   mc_output_decode u_decode (
      .i_state      (r_state_q),
      .i_op         (bus.op),
      .i_mem_ready  (bus.mem_ready),
      .i_zero       (bus.zero),
      .o_mem_req    (w_mem_req),
      .o_pc_write   (bus.PCWrite),
      .o_adr_src    (bus.AdrSrc),
      .o_mem_write  (bus.MemWrite),
      .o_ir_write   (bus.IRWrite),
      .o_reg_write  (bus.RegWrite),
      .o_result_src (bus.ResultSrc),
      .o_alu_src_a  (bus.ALUSrcA),
      .o_alu_src_b  (bus.ALUSrcB),
      .o_alu_op     (bus.ALUOp),
      .o_imm_src    (bus.ImmSrc),
      .o_trap       (bus.trap)
   );

   assign w_stall = w_mem_req & ~bus.mem_ready;
   // A ready on the limit cycle completes the access; only a real stall traps.
   assign w_limit = (MEM_TIMEOUT != 0) && w_stall && (r_wait_q == WaitLimit);

   always_comb begin
      w_state_d = r_state_q;
      w_cause_d = r_cause_q;

      unique case (r_state_q)
         StFetch: begin
            if (bus.mem_ready) w_state_d = StDecode;
         end
         StDecode: begin
            case (bus.op)
               OP_LW, OP_SW: w_state_d = StMemAdr;
               OP_R:         w_state_d = StExecR;
               OP_I:         w_state_d = StExecI;
               OP_BEQ:       w_state_d = StBeq;
`ifdef MC_JAL_EN
               OP_JAL:       w_state_d = StJal;
`endif
               default: begin
                  w_state_d = StTrap;
                  w_cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         StMemAdr:   w_state_d = (bus.op == OP_SW) ? StMemWrite : StMemRead;
         StMemRead: begin
            if (bus.mem_ready) w_state_d = StMemWb;
         end
         StMemWb:    w_state_d = StFetch;
         StMemWrite: begin
            if (bus.mem_ready) w_state_d = StFetch;
         end
         StExecR:    w_state_d = StAluWb;
         StExecI:    w_state_d = StAluWb;
         StAluWb:    w_state_d = StFetch;
         StBeq:      w_state_d = StFetch;
`ifdef MC_JAL_EN
         StJal:      w_state_d = StAluWb;
`endif
         StTrap: begin
            if (bus.trap_clr) begin
               w_state_d = StFetch;
               w_cause_d = CAUSE_NONE;
            end
         end
         default:    w_state_d = StFetch;
      endcase

      if (w_limit) begin
         w_state_d = StTrap;
         w_cause_d = CAUSE_TIMEOUT;
      end
   end

   always_comb begin
      w_wait_d = r_wait_q;
      if (w_state_d != r_state_q) begin
         w_wait_d = '0;
      end else if (w_stall) begin
         w_wait_d = r_wait_q + 1'b1;
      end
   end

   assign w_retire = (w_state_d == StFetch) &&
                     (r_state_q inside {StMemWb, StMemWrite, StAluWb, StBeq});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_q   <= StFetch;
         r_wait_q    <= '0;
         r_cause_q   <= CAUSE_NONE;
         r_retired_q <= '0;
      end else begin
         r_state_q <= w_state_d;
         r_wait_q  <= w_wait_d;
         r_cause_q <= w_cause_d;
         if (w_retire) r_retired_q <= r_retired_q + 1'b1;
      end
   end

   assign bus.mem_req    = w_mem_req;
   assign bus.trap_cause = r_cause_q;
   assign bus.retired    = r_retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each test plans per-cycle states,
// expected control words are queued at drive time and compared at negedge.
module tb_multicycle_controller;

   localparam int unsigned TIMEOUT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_controller_if #(.CNT_W(32)) bus ();

   multicycle_controller #(
      .MEM_TIMEOUT (TIMEOUT),
      .WAIT_W      (5),
      .CNT_W       (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef enum {
      TbFetch, TbDecode, TbMemAdr, TbMemRead, TbMemWb, TbMemWrite,
      TbExecR, TbExecI, TbAluWb, TbBeq, TbJal, TbTrap
   } tb_st_e;

   typedef struct packed {
      logic        mem_req;
      logic        pc_write;
      logic        adr_src;
      logic        mem_write;
      logic        ir_write;
      logic        reg_write;
      logic [1:0]  result_src;
      logic [1:0]  src_a;
      logic [1:0]  src_b;
      logic [1:0]  alu_op;
      logic [1:0]  imm_src;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] retired;
   } ctl_t;

   typedef struct {
      tb_st_e     st;
      logic       rdy;
      logic       z;
      logic       clr;
      logic [1:0] cause;
      logic       ret;
   } cyc_t;

   cyc_t        plan[$];
   ctl_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ret = 32'd0;

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
`ifdef MC_JAL_EN
         7'b1101111: return 2'b11;
`endif
         default:    return 2'b00;
      endcase
   endfunction

   function automatic ctl_t expect_for(input tb_st_e s, input logic rdy, input logic z,
                                       input logic [6:0] op, input logic [1:0] cause,
                                       input logic [31:0] ret);
      ctl_t c;
      c = '0;
      c.imm_src = imm_of(op);
      c.cause   = cause;
      c.retired = ret;
      case (s)
         TbFetch: begin
            c.mem_req = 1; c.src_b = 2'b10; c.result_src = 2'b10;
            c.ir_write = rdy; c.pc_write = rdy;
         end
         TbDecode:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
         TbMemAdr:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
         TbMemRead:  begin c.mem_req = 1; c.adr_src = 1; end
         TbMemWb:    begin c.result_src = 2'b01; c.reg_write = 1; end
         TbMemWrite: begin c.mem_req = 1; c.adr_src = 1; c.mem_write = 1; end
         TbExecR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
         TbExecI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
         TbAluWb:    c.reg_write = 1;
         TbBeq:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.pc_write = z; end
         TbJal:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1; end
         TbTrap:     c.trap = 1;
         default:    c = c;
      endcase
      return c;
   endfunction

   function automatic ctl_t observe();
      ctl_t g;
      g.mem_req = bus.mem_req;     g.pc_write = bus.PCWrite;   g.adr_src = bus.AdrSrc;
      g.mem_write = bus.MemWrite;  g.ir_write = bus.IRWrite;   g.reg_write = bus.RegWrite;
      g.result_src = bus.ResultSrc; g.src_a = bus.ALUSrcA;     g.src_b = bus.ALUSrcB;
      g.alu_op = bus.ALUOp;        g.imm_src = bus.ImmSrc;     g.trap = bus.trap;
      g.cause = bus.trap_cause;    g.retired = bus.retired;
      return g;
   endfunction

   function automatic void p(input tb_st_e st, input logic rdy, input logic z,
                             input logic clr, input logic [1:0] cause, input logic ret);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.z = z; c.clr = clr; c.cause = cause; c.ret = ret;
      plan.push_back(c);
   endfunction

   // Apply the head of the plan and queue its expected control word.
   task automatic drive(input logic [6:0] op);
      cyc_t c;
      c = plan[0];
      bus.op = op; bus.mem_ready = c.rdy; bus.zero = c.z; bus.trap_clr = c.clr;
      exp_q.push_back(expect_for(c.st, c.rdy, c.z, op, c.cause, exp_ret));
      @(negedge clk);
   endtask

   task automatic advance();
      cyc_t c;
      c = plan.pop_front();
      @(posedge clk);
      #1;
      if (c.ret) exp_ret = exp_ret + 32'd1;
   endtask

   task automatic test_reset();
      ctl_t e, g;
      #2;
      exp_q.push_back(expect_for(TbFetch, 1'b0, 1'b0, 7'b0, 2'b00, 32'd0));
      e = exp_q.pop_front(); g = observe(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset: got %h, expected %h", g, e); end
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbExecR, 0, 0, 0, 0, 0); p(TbAluWb, 0, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b0110011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL add: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_lw_stall();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0); p(TbMemAdr, 0, 0, 0, 0, 0);
      p(TbMemRead, 0, 0, 0, 0, 0); p(TbMemRead, 0, 0, 0, 0, 0); p(TbMemRead, 0, 0, 0, 0, 0);
      p(TbMemRead, 1, 0, 0, 0, 0); p(TbMemWb, 0, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b0000011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL lw_stall: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_sw_itype();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbMemAdr, 0, 0, 0, 0, 0); p(TbMemWrite, 1, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b0100011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL sw: got %h, expected %h", g, e); end
         advance();
      end
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbExecI, 0, 0, 0, 0, 0); p(TbAluWb, 0, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b0010011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL itype: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_beq();
      ctl_t e, g;
      p(TbFetch, 1, 1, 0, 0, 0); p(TbDecode, 0, 1, 0, 0, 0); p(TbBeq, 0, 1, 0, 0, 1);
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0); p(TbBeq, 0, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b1100011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL beq: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_illegal();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbTrap, 1, 1, 0, 1, 0); p(TbTrap, 0, 0, 1, 1, 0);
      while (plan.size() != 0) begin
         drive(7'b1111111); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL illegal: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_timeout();
      ctl_t e, g;
      for (int i = 0; i < int'(TIMEOUT); i++) p(TbFetch, 0, 0, 0, 0, 0);
      p(TbTrap, 0, 0, 0, 2, 0); p(TbTrap, 0, 0, 1, 2, 0);
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) p(TbFetch, 0, 0, 0, 0, 0);
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbExecR, 0, 0, 0, 0, 0); p(TbAluWb, 0, 0, 0, 0, 1);
      while (plan.size() != 0) begin
         drive(7'b0110011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL timeout: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_jal();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
`ifdef MC_JAL_EN
      p(TbJal, 0, 0, 0, 0, 0); p(TbAluWb, 0, 0, 0, 0, 1);
`else
      p(TbTrap, 0, 0, 1, 1, 0);
`endif
      while (plan.size() != 0) begin
         drive(7'b1101111); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL jal: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   task automatic test_reset_mid_write();
      ctl_t e, g;
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0); p(TbMemAdr, 0, 0, 0, 0, 0);
      while (plan.size() != 0) begin
         drive(7'b0100011); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL rst_write: got %h, expected %h", g, e); end
         advance();
      end
      bus.mem_ready = 1'b0;
      exp_q.push_back(expect_for(TbMemWrite, 1'b0, 1'b0, 7'b0100011, 2'b00, exp_ret));
      #2;
      e = exp_q.pop_front(); g = observe(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rst_write_pre: got %h, expected %h", g, e); end
      reset = 1'b1;
      exp_ret = 32'd0;
      exp_q.push_back(expect_for(TbFetch, 1'b0, 1'b0, 7'b0100011, 2'b00, exp_ret));
      #1;
      e = exp_q.pop_front(); g = observe(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rst_write_post: got %h, expected %h", g, e); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      ctl_t e, g;
      logic [6:0] ops[$];
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0);
      p(TbExecR, 0, 0, 0, 0, 0); p(TbAluWb, 0, 0, 0, 0, 1);
      p(TbFetch, 1, 0, 0, 0, 0); p(TbDecode, 0, 0, 0, 0, 0); p(TbMemAdr, 0, 0, 0, 0, 0);
      p(TbMemRead, 1, 0, 0, 0, 0); p(TbMemWb, 0, 0, 0, 0, 1); p(TbFetch, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) ops.push_back(7'b0110011);
      for (int i = 0; i < 6; i++) ops.push_back(7'b0000011);
      while (plan.size() != 0) begin
         drive(ops.pop_front()); e = exp_q.pop_front(); g = observe(); n_cmp++;
         if (g !== e) begin n_bad++; $display("FAIL back_to_back: got %h, expected %h", g, e); end
         advance();
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.op = 7'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0; bus.trap_clr = 1'b0;
      test_reset();
      test_add();
      test_lw_stall();
      test_sw_itype();
      test_beq();
      test_illegal();
      test_timeout();
      test_jal();
      test_reset_mid_write();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
